// File: rtl/exec_cc_stage.sv
// Y86-64 execute-stage back end: condition-code register, branch/cmov condition
// evaluation, cmov destination cancel and the E/M pipeline register.
module exec_cc_stage #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] INOP  = 4'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valE,
  input  logic             e_alu_of,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             cc_block,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             e_cnd,
  output logic [3:0]       e_dstE_eff,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic [3:0]       M_ifun,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_OPQ   = 4'h6;

  // Condition table shared by jXX and cmovXX; ifun values above 6 never fire.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = lt | zf;
      4'h2:    cond_eval = lt;
      4'h3:    cond_eval = zf;
      4'h4:    cond_eval = ~zf;
      4'h5:    cond_eval = ~lt;
      4'h6:    cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic cnd_s;
  logic [3:0] dste_eff_s;
  logic cc_we_s;

  // Condition from the registered flags, cmov cancel and CC write enable.
  always_comb begin
    cnd_s      = cond_eval(e_ifun, cc_zf, cc_sf, cc_of);
    dste_eff_s = e_dstE;
    if ((e_icode == I_RRMOV) && !cnd_s) begin
      dste_eff_s = RNONE;
    end else begin
      dste_eff_s = e_dstE;
    end
    cc_we_s = e_valid & (e_icode == I_OPQ) & ~cc_block & ~m_stall;
  end

  assign e_cnd      = cnd_s;
  assign e_dstE_eff = dste_eff_s;

  // Condition-code register; a stall also freezes the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (cc_we_s) begin
      cc_zf <= (e_valE == {WIDTH{1'b0}});
      cc_sf <= e_valE[WIDTH-1];
      cc_of <= e_alu_of;
    end else begin
      cc_zf <= cc_zf;
      cc_sf <= cc_sf;
      cc_of <= cc_of;
    end
  end

  // E/M pipeline register: stall beats bubble beats load; an empty slot loads a nop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_valid <= 1'b0;
      M_icode <= INOP;
      M_ifun  <= 4'h0;
      M_cnd   <= 1'b0;
      M_valE  <= {WIDTH{1'b0}};
      M_valA  <= {WIDTH{1'b0}};
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (m_stall) begin
      M_valid <= M_valid;
      M_icode <= M_icode;
      M_ifun  <= M_ifun;
      M_cnd   <= M_cnd;
      M_valE  <= M_valE;
      M_valA  <= M_valA;
      M_dstE  <= M_dstE;
      M_dstM  <= M_dstM;
    end else if (m_bubble || !e_valid) begin
      M_valid <= 1'b0;
      M_icode <= INOP;
      M_ifun  <= 4'h0;
      M_cnd   <= 1'b0;
      M_valE  <= {WIDTH{1'b0}};
      M_valA  <= {WIDTH{1'b0}};
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_valid <= 1'b1;
      M_icode <= e_icode;
      M_ifun  <= e_ifun;
      M_cnd   <= cnd_s;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= dste_eff_s;
      M_dstM  <= e_dstM;
    end
  end

endmodule
